synapse_fetch: RTL and testbench

SYNAPSE_FETCH -- requirements
Module: synapse_fetch

---
 rtl/synapse_fetch.sv | 154 +++++++++++++++
 tb/tb_synapse_fetch.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/synapse_fetch.sv
// synapse_fetch: queues inbound spikes, looks up each source's weight and presents it downstream.
// Define SYNAPSE_ZERO_SKIP_EN to drop spikes whose fetched weight is zero (counted in skip_count).
module synapse_fetch #(
  parameter int WEIGHT_WIDTH = 8,
  parameter int ADDR_WIDTH   = 8,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [15:0]                   spike_in_id,
  input  logic                          spike_in_valid,
  output logic                          spike_in_ready,
  input  logic                          cfg_we,
  input  logic [ADDR_WIDTH-1:0]         cfg_addr,
  input  logic [WEIGHT_WIDTH-1:0]       cfg_wdata,
  output logic [15:0]                   input_neuron_id,
  output logic [WEIGHT_WIDTH-1:0]       synapse_weight,
  output logic                          spike_out_valid,
  input  logic                          spike_out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [7:0]                    drop_count,
  output logic [7:0]                    skip_count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_FETCH   = 2'd1;
  localparam logic [1:0] S_PRESENT = 2'd2;

  logic [1:0]              state_q, state_d;
  logic [CW-1:0]           count_q, count_d;
  logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH-1:0]   fetch_id_q, fetch_id_d;
  logic [15:0]             out_id_q, out_id_d;
  logic [WEIGHT_WIDTH-1:0] out_weight_q, out_weight_d;
  logic                    out_valid_q, out_valid_d;
  logic [7:0]              drop_q, drop_d;
  logic [7:0]              skip_q, skip_d;
  logic                    run_q, run_d;

  logic [ADDR_WIDTH-1:0]   fifo_mem [FIFO_DEPTH];
  logic [WEIGHT_WIDTH-1:0] weight_mem [2**ADDR_WIDTH];
  logic [WEIGHT_WIDTH-1:0] rd_data_q;

  logic [ADDR_WIDTH-1:0]   head_id;
  logic                    in_range, accept, push, drop_evt, pop, skip_zero, skip_evt;

  // run_q delays acceptance by one edge after reset release so the release is seen synchronously
  assign spike_in_ready = !rst_n || (run_q && (count_q < CW'(FIFO_DEPTH)));

  assign in_range = ((spike_in_id >> ADDR_WIDTH) == 16'd0);
  assign accept   = spike_in_valid && spike_in_ready && run_q;
  assign push     = accept && in_range;
  assign drop_evt = accept && !in_range;
  assign pop      = (state_q == S_IDLE) && (count_q != '0);
  assign head_id  = fifo_mem[rd_ptr_q];

`ifdef SYNAPSE_ZERO_SKIP_EN
  assign skip_zero = (rd_data_q == '0);
`else
  assign skip_zero = 1'b0;
`endif

  assign input_neuron_id = out_id_q;
  assign synapse_weight  = out_weight_q;
  assign spike_out_valid = out_valid_q;
  assign fifo_count      = count_q;
  assign drop_count      = drop_q;
  assign skip_count      = skip_q;

  always_comb begin
    run_d    = 1'b1;
    count_d  = count_q + CW'(push) - CW'(pop);
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    drop_d   = (drop_evt && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;
  end

  always_comb begin
    state_d      = state_q;
    fetch_id_d   = fetch_id_q;
    out_id_d     = out_id_q;
    out_weight_d = out_weight_q;
    out_valid_d  = out_valid_q;
    skip_evt     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pop) begin
          fetch_id_d = head_id;
          state_d    = S_FETCH;
        end
      end
      S_FETCH: begin
        if (skip_zero) begin
          skip_evt = 1'b1;
          state_d  = S_IDLE;
        end else begin
          out_id_d                   = '0;
          out_id_d[ADDR_WIDTH-1:0]   = fetch_id_q;
          out_weight_d               = rd_data_q;
          out_valid_d                = 1'b1;
          state_d                    = S_PRESENT;
        end
      end
      S_PRESENT: begin
        if (spike_out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    skip_d = (skip_evt && skip_q != 8'hFF) ? skip_q + 8'd1 : skip_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q        <= 1'b0;
      state_q      <= S_IDLE;
      count_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fetch_id_q   <= '0;
      out_id_q     <= '0;
      out_weight_q <= '0;
      out_valid_q  <= 1'b0;
      drop_q       <= '0;
      skip_q       <= '0;
    end else begin
      run_q        <= run_d;
      state_q      <= state_d;
      count_q      <= count_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fetch_id_q   <= fetch_id_d;
      out_id_q     <= out_id_d;
      out_weight_q <= out_weight_d;
      out_valid_q  <= out_valid_d;
      drop_q       <= drop_d;
      skip_q       <= skip_d;
    end
  end

  // Storage arrays carry no reset; a same-edge write and read of one address returns the old weight
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= spike_in_id[ADDR_WIDTH-1:0];
    if (cfg_we) weight_mem[cfg_addr] <= cfg_wdata;
    if (pop) rd_data_q <= weight_mem[head_id];
  end

endmodule

// File: tb/tb_synapse_fetch.sv
// tb_synapse_fetch: directed and random spikes checked against a queue-based model of synapse_fetch.
// Expectations follow SYNAPSE_ZERO_SKIP_EN when the bench is built with it.
module tb_synapse_fetch;

  logic        clk;
  logic        rst_n;
  logic [15:0] spike_in_id;
  logic        spike_in_valid;
  logic        spike_in_ready;
  logic        cfg_we;
  logic [7:0]  cfg_addr;
  logic [7:0]  cfg_wdata;
  logic [15:0] input_neuron_id;
  logic [7:0]  synapse_weight;
  logic        spike_out_valid;
  logic        spike_out_ready;
  logic [2:0]  fifo_count;
  logic [7:0]  drop_count;
  logic [7:0]  skip_count;

`ifdef SYNAPSE_ZERO_SKIP_EN
  localparam bit ZeroSkip = 1'b1;
`else
  localparam bit ZeroSkip = 1'b0;
`endif

  int          compared;
  int          mismatched;
  logic [7:0]  weightModel [256];
  logic [23:0] expQ [$];
  int          dropModel;
  int          skipModel;
  logic        inAccepted;
  logic        newValid;
  logic [15:0] newId;

  synapse_fetch #(.WEIGHT_WIDTH(8), .ADDR_WIDTH(8), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .spike_in_id(spike_in_id), .spike_in_valid(spike_in_valid), .spike_in_ready(spike_in_ready),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .input_neuron_id(input_neuron_id), .synapse_weight(synapse_weight),
    .spike_out_valid(spike_out_valid), .spike_out_ready(spike_out_ready),
    .fifo_count(fifo_count), .drop_count(drop_count), .skip_count(skip_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Handshakes are recorded at the falling edge, where the inputs for the next rising edge are stable
  task automatic tick();
    logic [23:0] expItem;
    @(negedge clk);
    inAccepted = 1'b0;
    if (rst_n) begin
      if (spike_in_valid && spike_in_ready) begin
        inAccepted = 1'b1;
        if (spike_in_id[15:8] != 8'h00) begin
          if (dropModel < 255) dropModel++;
        end else if (ZeroSkip && weightModel[spike_in_id[7:0]] == 8'h00) begin
          if (skipModel < 255) skipModel++;
        end else begin
          expQ.push_back({spike_in_id, weightModel[spike_in_id[7:0]]});
        end
      end
      if (spike_out_valid && spike_out_ready) begin
        checkOutput("out_expected", 32'(expQ.size() > 0), 32'd1);
        if (expQ.size() > 0) begin
          expItem = expQ.pop_front();
          checkOutput("out_id", 32'(input_neuron_id), 32'(expItem[23:8]));
          checkOutput("out_weight", 32'(synapse_weight), 32'(expItem[7:0]));
        end
      end
    end
    if (cfg_we) weightModel[cfg_addr] = cfg_wdata;
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic valid, input logic [15:0] id, input logic outReady);
    spike_in_valid  = valid;
    spike_in_id     = id;
    spike_out_ready = outReady;
    tick();
  endtask

  task automatic pushId(input logic [15:0] id);
    spike_in_valid = 1'b1;
    spike_in_id    = id;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (inAccepted) break;
    end
    spike_in_valid = 1'b0;
    checkOutput("push_accepted", 32'(inAccepted), 32'd1);
  endtask

  task automatic writeWeight(input logic [7:0] addr, input logic [7:0] data);
    cfg_we    = 1'b1;
    cfg_addr  = addr;
    cfg_wdata = data;
    tick();
    cfg_we    = 1'b0;
  endtask

  initial begin
    compared = 0; mismatched = 0; dropModel = 0; skipModel = 0; inAccepted = 1'b0;
    rst_n = 1'b0; spike_in_valid = 1'b0; spike_in_id = '0; spike_out_ready = 1'b0;
    cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    newValid = 1'b0; newId = '0;
    for (int a = 0; a < 256; a++) weightModel[a] = 8'h00;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_valid", 32'(spike_out_valid), 32'd0);
    checkOutput("rst_count", 32'(fifo_count), 32'd0);
    checkOutput("rst_ready", 32'(spike_in_ready), 32'd1);
    checkOutput("rst_id", 32'(input_neuron_id), 32'd0);
    checkOutput("rst_weight", 32'(synapse_weight), 32'd0);
    checkOutput("rst_drop", 32'(drop_count), 32'd0);
    checkOutput("rst_skip", 32'(skip_count), 32'd0);

    rst_n = 1'b1;
    repeat (2) tick();
    for (int a = 0; a < 256; a++) writeWeight(8'(a), 8'($urandom_range(1, 255)));
    writeWeight(8'd5, 8'h7F);
    writeWeight(8'd3, 8'h00);
    writeWeight(8'd7, 8'h80);

    // Single spike: valid two edges after the push, then one transfer
    applyStimulus(1'b1, 16'd5, 1'b1);
    checkOutput("lat_n0_valid", 32'(spike_out_valid), 32'd0);
    applyStimulus(1'b0, 16'd0, 1'b1);
    checkOutput("lat_n1_valid", 32'(spike_out_valid), 32'd0);
    applyStimulus(1'b0, 16'd0, 1'b1);
    checkOutput("lat_n2_valid", 32'(spike_out_valid), 32'd1);
    checkOutput("lat_n2_id", 32'(input_neuron_id), 32'd5);
    checkOutput("lat_n2_weight", 32'(synapse_weight), 32'h7F);
    applyStimulus(1'b0, 16'd0, 1'b1);
    checkOutput("lat_n3_valid", 32'(spike_out_valid), 32'd0);
    checkOutput("retain_id", 32'(input_neuron_id), 32'd5);
    checkOutput("retain_weight", 32'(synapse_weight), 32'h7F);
    checkOutput("lat_drained", 32'(expQ.size()), 32'd0);

    // Backpressure: fill the queue behind a held presentation
    spike_out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) pushId(16'(i));
    checkOutput("bp_count3", 32'(fifo_count), 32'd3);
    pushId(16'd5);
    checkOutput("bp_count4", 32'(fifo_count), 32'd4);
    checkOutput("bp_ready_full", 32'(spike_in_ready), 32'd0);
    repeat (3) applyStimulus(1'b0, 16'd0, 1'b0);
    checkOutput("bp_hold_valid", 32'(spike_out_valid), 32'd1);
    checkOutput("bp_hold_id", 32'(input_neuron_id), 32'd1);
    checkOutput("bp_hold_weight", 32'(synapse_weight), 32'(weightModel[1]));
    repeat (20) applyStimulus(1'b0, 16'd0, 1'b1);
    checkOutput("bp_drained", 32'(expQ.size()), 32'd0);
    checkOutput("bp_count0", 32'(fifo_count), 32'd0);

    // Out-of-range IDs are accepted and counted, never emitted
    pushId(16'h0100);
    repeat (4) applyStimulus(1'b0, 16'd0, 1'b1);
    checkOutput("drop_one", 32'(drop_count), 32'd1);
    checkOutput("drop_no_valid", 32'(spike_out_valid), 32'd0);
    checkOutput("drop_count_fifo", 32'(fifo_count), 32'd0);
    for (int i = 1; i < 300; i++) pushId({8'($urandom_range(1, 255)), 8'($urandom)});
    checkOutput("drop_sat", 32'(drop_count), 32'd255);

    pushId(16'd3);
    repeat (6) applyStimulus(1'b0, 16'd0, 1'b1);
    checkOutput("zero_skip_count", 32'(skip_count), 32'(skipModel));
    checkOutput("zero_drained", 32'(expQ.size()), 32'd0);

    // Weight rewrite on the same edge as the read of that address
    pushId(16'd7);
    cfg_we = 1'b1; cfg_addr = 8'd7; cfg_wdata = 8'h10;
    applyStimulus(1'b0, 16'd0, 1'b1);
    cfg_we = 1'b0;
    repeat (4) applyStimulus(1'b0, 16'd0, 1'b1);
    checkOutput("rw_old_weight", 32'(synapse_weight), 32'h80);
    checkOutput("rw_old_id", 32'(input_neuron_id), 32'd7);
    pushId(16'd7);
    repeat (5) applyStimulus(1'b0, 16'd0, 1'b1);
    checkOutput("rw_new_weight", 32'(synapse_weight), 32'h10);
    checkOutput("rw_drained", 32'(expQ.size()), 32'd0);

    // Reset while presenting with two spikes queued
    spike_out_ready = 1'b0;
    pushId(16'd10);
    pushId(16'd11);
    pushId(16'd12);
    checkOutput("mid_valid", 32'(spike_out_valid), 32'd1);
    checkOutput("mid_count", 32'(fifo_count), 32'd2);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_valid", 32'(spike_out_valid), 32'd0);
    checkOutput("mid_rst_count", 32'(fifo_count), 32'd0);
    checkOutput("mid_rst_ready", 32'(spike_in_ready), 32'd1);
    checkOutput("mid_rst_drop", 32'(drop_count), 32'd0);
    expQ.delete();
    dropModel = 0;
    skipModel = 0;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (10) applyStimulus(1'b0, 16'd0, 1'b1);
    checkOutput("post_rst_valid", 32'(spike_out_valid), 32'd0);
    checkOutput("post_rst_count", 32'(fifo_count), 32'd0);

    // Random traffic; valid and ID held until each spike is accepted
    for (int c = 0; c < 400; c++) begin
      if (!newValid || inAccepted) begin
        newValid = 1'($urandom_range(0, 1));
        newId = ($urandom_range(0, 7) == 0) ? {8'($urandom_range(1, 255)), 8'($urandom)}
                                            : {8'h00, 8'($urandom)};
      end
      applyStimulus(newValid, newId, $urandom_range(0, 3) != 0);
    end
    repeat (30) applyStimulus(1'b0, 16'd0, 1'b1);
    checkOutput("rand_drained", 32'(expQ.size()), 32'd0);
    checkOutput("rand_drop", 32'(drop_count), 32'(dropModel));
    checkOutput("rand_skip", 32'(skip_count), 32'(skipModel));
    checkOutput("rand_count", 32'(fifo_count), 32'd0);
    checkOutput("rand_valid", 32'(spike_out_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
